// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// control_pkg : decoded control bundle, ID/EX bundle and stage-state types
// Revision    : 1.0
// ============================================================================
package control_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] rd;
    logic       regwen;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic       branch;
    logic       jump;
  } control_signals_t;

  typedef struct packed {
    control_signals_t  ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
  } id_ex_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_reg_slice.sv
`default_nettype none
// ============================================================================
// pipe_reg_slice : one ID/EX bundle register with load enable and valid clear
// Revision       : 1.0
// ============================================================================
module pipe_reg_slice
  import control_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  id_ex_bundle_t i_d,
  output id_ex_bundle_t o_q,
  output logic          o_valid
);

  id_ex_bundle_t r_q;
  logic          r_valid;

  // Clear wins over load; the payload is kept on clear and only zeroed by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_q     <= i_d;
      r_valid <= 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// id_ex_pipe : ID->EX pipeline stage; ID_EX_SKID_EN adds skid reg + FULL state
// Revision   : 1.0
// ============================================================================
module id_ex_pipe #(
  parameter int XLEN = control_pkg::XLEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  control_pkg::control_signals_t in_ctrl,
  input  logic [XLEN-1:0]               in_pc,
  input  logic [XLEN-1:0]               in_rs1_data,
  input  logic [XLEN-1:0]               in_rs2_data,
  input  logic [XLEN-1:0]               in_imm,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output control_pkg::control_signals_t out_ctrl,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_rs1_data,
  output logic [XLEN-1:0]               out_rs2_data,
  output logic [XLEN-1:0]               out_imm
);

  import control_pkg::*;

  stage_state_t  r_state;
  stage_state_t  w_state_nxt;
  id_ex_bundle_t w_in_bundle;
  id_ex_bundle_t w_main_d;
  id_ex_bundle_t w_main_q;
  logic          w_main_load;
  logic          w_main_clear;
  logic          w_main_valid;
  logic          w_xfer_in;
  logic          w_xfer_out;

  assign w_in_bundle = '{ctrl: in_ctrl, pc: in_pc, rs1_data: in_rs1_data,
                         rs2_data: in_rs2_data, imm: in_imm};

  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = w_main_valid && out_ready;

  pipe_reg_slice u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_d     (w_main_d),
    .o_q     (w_main_q),
    .o_valid (w_main_valid)
  );

`ifdef ID_EX_SKID_EN
  id_ex_bundle_t w_skid_q;
  logic          w_skid_load;
  logic          w_skid_clear;
  logic          w_skid_valid;
  logic          r_in_ready;

  pipe_reg_slice u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_d     (w_in_bundle),
    .o_q     (w_skid_q),
    .o_valid (w_skid_valid)
  );

  // Registered ready: decode never sees a path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) r_in_ready <= 1'b1;
    else     r_in_ready <= (w_state_nxt != ST_FULL);
  end

  assign in_ready = r_in_ready;
  assign w_main_d = w_skid_valid ? w_skid_q : w_in_bundle;
`else
  assign in_ready = !w_main_valid || out_ready;
  assign w_main_d = w_in_bundle;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
`ifdef ID_EX_SKID_EN
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
`endif
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_main_clear = 1'b1;
`ifdef ID_EX_SKID_EN
      w_skid_clear = 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer_in) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (w_xfer_in && w_xfer_out) begin
            w_main_load = 1'b1;
`ifdef ID_EX_SKID_EN
          end else if (w_xfer_in) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_FULL;
`endif
          end else if (w_xfer_out) begin
            w_main_clear = 1'b1;
            w_state_nxt  = ST_EMPTY;
          end
        end
`ifdef ID_EX_SKID_EN
        ST_FULL: begin
          if (w_xfer_out) begin
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = ST_MAIN;
          end
        end
`endif
        default: begin
          w_main_clear = 1'b1;
          w_state_nxt  = ST_EMPTY;
        end
      endcase
    end
  end

  // A bubble must never write the register file.
  always_comb begin
    out_ctrl        = w_main_q.ctrl;
    out_ctrl.regwen = w_main_q.ctrl.regwen & w_main_valid;
  end

  assign out_valid    = w_main_valid;
  assign out_pc       = w_main_q.pc;
  assign out_rs1_data = w_main_q.rs1_data;
  assign out_rs2_data = w_main_q.rs2_data;
  assign out_imm      = w_main_q.imm;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// tb_id_ex_pipe : directed scoreboard bench for id_ex_pipe (both skid builds)
// Revision      : 1.0
// ============================================================================
module tb_id_ex_pipe;
  import control_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  control_signals_t in_ctrl;
  logic [31:0]      in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  control_signals_t out_ctrl;
  logic [31:0]      out_pc, out_rs1_data, out_rs2_data, out_imm;

  int n_vec = 0;
  int n_err = 0;
  id_ex_bundle_t sb[$];

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic id_ex_bundle_t mk(input logic [31:0] pc, input logic [4:0] rd);
    id_ex_bundle_t b;
    b             = '0;
    b.pc          = pc;
    b.rs1_data    = pc ^ 32'hA5A5_0000;
    b.rs2_data    = ~pc;
    b.imm         = pc + 32'd1;
    b.ctrl.rd     = rd;
    b.ctrl.regwen = 1'b1;
    b.ctrl.alu_op = pc[5:2];
    b.ctrl.alusrc = pc[2];
    return b;
  endfunction

  task automatic drive(input id_ex_bundle_t b);
    in_valid    = 1'b1;
    in_ctrl     = b.ctrl;
    in_pc       = b.pc;
    in_rs1_data = b.rs1_data;
    in_rs2_data = b.rs2_data;
    in_imm      = b.imm;
  endtask

  // Offer a bundle for one cycle; push it only if the stage takes it.
  task automatic offer(input id_ex_bundle_t b, input logic rdy, input logic exp_rdy);
    @(posedge clk); #1;
    out_ready = rdy;
    drive(b);
    @(negedge clk);
    chk("in_ready_on_offer", in_ready, exp_rdy);
    if (in_ready) sb.push_back(b);
  endtask

  task automatic idle(input logic rdy);
    @(posedge clk); #1;
    out_ready = rdy;
    in_valid  = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every output transfer must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got pc %0h, expected no transfer", out_pc);
      end else begin
        id_ex_bundle_t e;
        id_ex_bundle_t a;
        e = sb.pop_front();
        a = '{ctrl: out_ctrl, pc: out_pc, rs1_data: out_rs1_data,
              rs2_data: out_rs2_data, imm: out_imm};
        chk("out_pc", out_pc, e.pc);
        chk("out_payload_match", {63'd0, (a == e)}, 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    in_ctrl = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_regwen", out_ctrl.regwen, 0);
    chk("rst_out_pc", out_pc, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single pass
    offer(mk(32'h100, 5'd5), 1'b1, 1'b1);
    idle(1'b1);
    chk("single_out_valid", out_valid, 1);
    chk("single_rd", out_ctrl.rd, 5);
    idle(1'b1);
    chk("single_bubble_valid", out_valid, 0);
    chk("single_bubble_regwen", out_ctrl.regwen, 0);

    // Backpressure
    offer(mk(32'h100, 5'd1), 1'b0, 1'b1);
`ifdef ID_EX_SKID_EN
    offer(mk(32'h104, 5'd2), 1'b0, 1'b1);
`else
    offer(mk(32'h104, 5'd2), 1'b0, 1'b0);
`endif
    idle(1'b0);
    chk("bp_in_ready_c3", in_ready, 0);
    chk("bp_hold_pc", out_pc, 32'h100);
    idle(1'b0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_pc2", out_pc, 32'h100);
    idle(1'b1);
`ifdef ID_EX_SKID_EN
    chk("bp_ready_registered", in_ready, 0);
    idle(1'b1);
    chk("bp_second_pc", out_pc, 32'h104);
    chk("bp_ready_back", in_ready, 1);
`else
    chk("bp_ready_tracks", in_ready, 1);
`endif
    idle(1'b1);
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      offer(mk(32'h300 + 32'(4 * i), 5'(i + 8)), 1'b1, 1'b1);
      if (i > 0) chk("stream_b2b_valid", out_valid, 1);
    end
    idle(1'b1);
    chk("stream_last_valid", out_valid, 1);
    chk("stream_last_pc", out_pc, 32'h31C);
    idle(1'b1);
    chk("stream_done_valid", out_valid, 0);
    chk("stream_sb_empty", sb.size(), 0);

    // Flush with bundles held
    offer(mk(32'h400, 5'd3), 1'b0, 1'b1);
`ifdef ID_EX_SKID_EN
    offer(mk(32'h404, 5'd4), 1'b0, 1'b1);
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(mk(32'h200, 5'd6));
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_regwen", out_ctrl.regwen, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("flush_stays_empty", out_valid, 0);
    end

    // Reset mid-stream
    offer(mk(32'h500, 5'd7), 1'b0, 1'b1);
`ifdef ID_EX_SKID_EN
    offer(mk(32'h504, 5'd9), 1'b0, 1'b1);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    drive(mk(32'h600, 5'd10));
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_regwen", out_ctrl.regwen, 0);
    chk("rstmid_out_pc", out_pc, 0);
    chk("rstmid_in_ready", in_ready, 1);
    idle(1'b1);
    chk("rstmid_stays_empty", out_valid, 0);
    chk("rstmid_in_ready2", in_ready, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter: XLEN, 32, datapath width of PC, operands and immediate.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  decode holds a valid instruction bundle.
REQ-005 Port: in_ready  output  1  stage accepts the bundle this cycle.
REQ-006 Port: in_ctrl  input  control_signals_t  decoded control bundle.
REQ-007 Port: in_pc / in_rs1_data / in_rs2_data / in_imm  input  XLEN each  PC, register-file reads, expanded immediate.
REQ-008 Port: flush  input  1  kill all held and incoming bundles (branch or jump redirect).
REQ-009 Port: out_valid  output  1  execute-side bundle valid.
REQ-010 Port: out_ready  input  1  execute consumes the bundle this cycle.
REQ-011 Port: out_ctrl / out_pc / out_rs1_data / out_rs2_data / out_imm  output  control_signals_t / XLEN each  registered bundle to execute.

Function
REQ-012 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready; each transfer moves exactly one bundle.
REQ-013 Latency SHALL be 1 cycle: a bundle accepted in cycle N appears on out_* in cycle N+1 when the stage was empty.
REQ-014 Storage SHALL be a main register (drives out_*) and a skid register; states are EMPTY, MAIN and FULL (main plus skid).
REQ-015 EMPTY: on transfer in, go to MAIN with main loaded.
REQ-016 MAIN: on in-only, go to FULL with skid loaded; on out-only, go to EMPTY; on both, stay in MAIN with main reloaded from in_*.
REQ-017 FULL: on transfer out, go to MAIN with main loaded from skid; no transfer in is possible in FULL.
REQ-018 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-019 out_* SHALL stay stable while out_valid && !out_ready.
REQ-020 Order SHALL be preserved: the skid bundle always leaves after the main bundle.
REQ-021 flush SHALL take priority over all transfers: next state is EMPTY, the incoming bundle is dropped and out_valid is 0 next cycle.
REQ-022 While out_valid=0, out_ctrl.regwen SHALL be forced to 0 so execute sees a bubble.
REQ-023 Payload is opaque: no field of control_signals_t is altered except regwen in a bubble.

Reset
REQ-024 While rst=1 at a clock edge: state is EMPTY, out_valid=0, in_ready=1 on the following cycle, and main and skid payloads are all-zero.
REQ-025 Reset mid-operation SHALL discard held bundles with no transfer out in that cycle; rst overrides flush.

Configuration
REQ-026 Macro ID_EX_SKID_EN defined: the skid register, FULL state and registered in_ready of REQ-014 to REQ-018 are compiled in.
REQ-027 Macro ID_EX_SKID_EN undefined: there is no skid register and no FULL state, and in_ready = !out_valid || out_ready combinationally; all other requirements hold.

Structure
REQ-028 control_pkg SHALL gain an id_ex_bundle_t packed struct (control_signals_t, pc, rs1_data, rs2_data, imm) with XLEN as a package constant, plus a stage-state enum (ST_EMPTY, ST_MAIN, ST_FULL).
REQ-029 One sub-module, pipe_reg_slice, holds a single bundle register with load enable and valid clear; id_ex_pipe instantiates it for main and, under ID_EX_SKID_EN, for skid.

Verification
REQ-030 Single pass: reset, out_ready=1, drive one bundle (pc=0x100, rd=5, regwen=1) -> out_valid=1 with out_pc=0x100 next cycle, then 0.
REQ-031 Backpressure: out_ready=0, drive pc=0x100 and pc=0x104 on consecutive cycles -> in_ready=0 from cycle 3 and out_pc held at 0x100; raise out_ready -> 0x100 then 0x104 emerge in order.
REQ-032 Streaming: in_valid=1 and out_ready=1 for 8 cycles with pc incrementing by 4 -> 8 outputs back-to-back, in_ready constantly 1, no loss or duplication.
REQ-033 Flush in FULL: with two bundles held, assert flush together with in_valid (pc=0x200) -> out_valid=0 next cycle, state EMPTY, and 0x200 never appears.
REQ-034 Reset mid-stream: assert rst while in FULL -> out_valid=0 and out_ctrl.regwen=0 next cycle, in_ready=1 afterwards.
REQ-035 Without ID_EX_SKID_EN: repeat REQ-031 -> in_ready tracks out_ready in the same cycle and only 0x100 is captured.
